// File: rtl/fp32_accumulator_pkg.sv
// Shared constants, state encodings and helpers for the FP32 accumulator and its adder.
// The accumulator owns the handshake; fp32_add_unit performs one rounded binary32 add per go pulse.
package fp32_accumulator_pkg;

    localparam logic signed [9:0] BIAS = 10'sd127;
    localparam logic signed [9:0] EMIN = -10'sd126;
    localparam logic signed [9:0] EMAX = 10'sd127;
    localparam logic [31:0]       QNAN = 32'hFFC00000;
    localparam logic [31:0]       PINF = 32'h7F800000;
    localparam logic [31:0]       NINF = 32'hFF800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WAIT_IN,
        ACC_CALC,
        ACC_DONE
    } acc_state_e;

    typedef enum logic [2:0] {
        ADD_IDLE,
        ADD_UNPACK,
        ADD_SPECIAL,
        ADD_ALIGN,
        ADD_ADD,
        ADD_NORM,
        ADD_ROUND,
        ADD_PACK
    } add_state_e;

    // Denormals and zero share the minimum exponent; the hidden bit carries the difference.
    function automatic logic signed [9:0] unpack_exp(input logic [7:0] field);
        logic signed [9:0] e;
        if (field == 8'd0) begin
            e = EMIN;
        end else begin
            e = $signed({2'b00, field}) - BIAS;
        end
        return e;
    endfunction

    function automatic logic [26:0] shift_right_sticky(input logic [26:0] m, input logic [9:0] amt);
        logic [26:0] shifted;
        logic [26:0] lost_mask;
        logic [26:0] res;
        if (amt >= 10'd27) begin
            res = {26'd0, |m};
        end else begin
            shifted   = m >> amt;
            lost_mask = ~(27'h7FFFFFF << amt);
            res       = {shifted[26:1], shifted[0] | (|(m & lost_mask))};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp32_add_unit.sv
// Multi-cycle binary32 adder, round-to-nearest-even, from operand capture to packed result.
// sum_o is valid while done_o is high (the PACK cycle).
module fp32_add_unit
    import fp32_accumulator_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        done_o
);

    add_state_e        state_q, state_d;
    fp32_t             a_q, a_d, b_q, b_d;
    logic              sa_q, sa_d, sb_q, sb_d, rs_q, rs_d;
    logic signed [9:0] ea_q, ea_d, eb_q, eb_d, re_q, re_d;
    logic [26:0]       ma_q, ma_d, mb_q, mb_d;
    logic [27:0]       rm_q, rm_d;
    logic              special_q, special_d;
    logic [31:0]       spec_res_q, spec_res_d;

    logic [9:0]        diff_s;
    logic [27:0]       sum_s;
    logic [24:0]       m25_s;
    logic              inc_s;
    logic              nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;

    assign nan_a_s  = (a_q.exp == 8'hFF) && (a_q.frac != 23'd0);
    assign nan_b_s  = (b_q.exp == 8'hFF) && (b_q.frac != 23'd0);
    assign inf_a_s  = (a_q.exp == 8'hFF) && (a_q.frac == 23'd0);
    assign inf_b_s  = (b_q.exp == 8'hFF) && (b_q.frac == 23'd0);
    assign zero_a_s = (a_q.exp == 8'h00) && (a_q.frac == 23'd0);
    assign zero_b_s = (b_q.exp == 8'h00) && (b_q.frac == 23'd0);

    // Next-state and datapath for the add sequence.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        rs_d       = rs_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        re_d       = re_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        rm_d       = rm_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        diff_s     = 10'd0;
        sum_s      = 28'd0;
        m25_s      = 25'd0;
        inc_s      = 1'b0;
        sum_o      = 32'd0;
        done_o     = 1'b0;
        case (state_q)
            ADD_IDLE: begin
                if (go_i) begin
                    a_d       = a_i;
                    b_d       = b_i;
                    special_d = 1'b0;
                    state_d   = ADD_UNPACK;
                end else begin
                    state_d = ADD_IDLE;
                end
            end
            ADD_UNPACK: begin
                sa_d    = a_q.sign;
                sb_d    = b_q.sign;
                ea_d    = unpack_exp(a_q.exp);
                eb_d    = unpack_exp(b_q.exp);
                ma_d    = {(a_q.exp != 8'd0), a_q.frac, 3'b000};
                mb_d    = {(b_q.exp != 8'd0), b_q.frac, 3'b000};
                state_d = ADD_SPECIAL;
            end
            ADD_SPECIAL: begin
                special_d = 1'b1;
                state_d   = ADD_PACK;
                if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (a_q.sign != b_q.sign))) begin
                    spec_res_d = QNAN;
                end else if (inf_a_s) begin
                    spec_res_d = a_q;
                end else if (inf_b_s) begin
                    spec_res_d = b_q;
                end else if (zero_a_s && zero_b_s) begin
                    spec_res_d = {a_q.sign & b_q.sign, 31'd0};
                end else if (zero_a_s) begin
                    spec_res_d = b_q;
                end else if (zero_b_s) begin
                    spec_res_d = a_q;
                end else begin
                    special_d = 1'b0;
                    state_d   = ADD_ALIGN;
                end
            end
            ADD_ALIGN: begin
                if (ea_q >= eb_q) begin
                    diff_s = ea_q - eb_q;
                    mb_d   = shift_right_sticky(mb_q, diff_s);
                    re_d   = ea_q;
                end else begin
                    diff_s = eb_q - ea_q;
                    ma_d   = shift_right_sticky(ma_q, diff_s);
                    re_d   = eb_q;
                end
                state_d = ADD_ADD;
            end
            ADD_ADD: begin
                if (sa_q == sb_q) begin
                    sum_s = {1'b0, ma_q} + {1'b0, mb_q};
                    rs_d  = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum_s = {1'b0, ma_q - mb_q};
                    rs_d  = sa_q;
                end else begin
                    sum_s = {1'b0, mb_q - ma_q};
                    rs_d  = sb_q;
                end
                rm_d = sum_s;
                // Exact cancellation: park the exponent at EMIN so NORM exits at once.
                if (sum_s == 28'd0) begin
                    rs_d = 1'b0;
                    re_d = EMIN;
                end else begin
                    re_d = re_q;
                end
                state_d = ADD_NORM;
            end
            ADD_NORM: begin
                if (rm_q[27]) begin
                    rm_d    = {1'b0, rm_q[27:2], rm_q[1] | rm_q[0]};
                    re_d    = re_q + 10'sd1;
                    state_d = ADD_ROUND;
                end else if (!rm_q[26] && (re_q > EMIN)) begin
                    rm_d    = {rm_q[26:0], 1'b0};
                    re_d    = re_q - 10'sd1;
                    state_d = ADD_NORM;
                end else begin
                    state_d = ADD_ROUND;
                end
            end
            ADD_ROUND: begin
                inc_s = rm_q[2] & (rm_q[1] | rm_q[0] | rm_q[3]);
                m25_s = {1'b0, rm_q[26:3]} + {24'd0, inc_s};
                if (m25_s[24]) begin
                    rm_d = {4'd0, m25_s[24:1]};
                    re_d = re_q + 10'sd1;
                end else begin
                    rm_d = {4'd0, m25_s[23:0]};
                    re_d = re_q;
                end
                state_d = ADD_PACK;
            end
            ADD_PACK: begin
                done_o  = 1'b1;
                state_d = ADD_IDLE;
                if (special_q) begin
                    sum_o = spec_res_q;
                end else if (re_q > EMAX) begin
                    sum_o = rs_q ? NINF : PINF;
                end else if ((re_q == EMIN) && !rm_q[23]) begin
                    sum_o = {rs_q, 8'h00, rm_q[22:0]};
                end else begin
                    sum_o = {rs_q, 8'(re_q + BIAS), rm_q[22:0]};
                end
            end
            default: begin
                state_d = ADD_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ADD_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            rs_q       <= 1'b0;
            ea_q       <= 10'sd0;
            eb_q       <= 10'sd0;
            re_q       <= 10'sd0;
            ma_q       <= 27'd0;
            mb_q       <= 27'd0;
            rm_q       <= 28'd0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            rs_q       <= rs_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            re_q       <= re_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            rm_q       <= rm_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
        end
    end

endmodule

// File: rtl/fp32_accumulator.sv
// Sums len FP32 products from the multiplier stream into one binary32 result.
// Keeps the product count, the running sum, the in_stb/in_rdy handshake and the sticky overrun flag.
module fp32_accumulator
    import fp32_accumulator_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      in_z,
    input  logic             in_stb,
    output logic             in_rdy,
    output logic [31:0]      acc_out,
    output logic             acc_stb,
    output logic             busy,
    output logic             overrun
);

    acc_state_e       state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      acc_q, acc_d;
    logic             overrun_q, overrun_d;
    logic [31:0]      acc_out_q;
    logic             acc_stb_q, busy_q, in_rdy_q;
    logic             go_s, add_done_s;
    logic [31:0]      add_sum_s;

    fp32_add_unit u_add (
        .clk    (clk),
        .rst    (rst),
        .go_i   (go_s),
        .a_i    (acc_q),
        .b_i    (in_z),
        .sum_o  (add_sum_s),
        .done_o (add_done_s)
    );

    // Reduction sequencing and overrun detection.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        overrun_d = overrun_q;
        go_s      = 1'b0;
        case (state_q)
            ACC_IDLE: begin
                if (start) begin
                    count_d   = len;
                    acc_d     = 32'd0;
                    overrun_d = 1'b0;
                    state_d   = (len == '0) ? ACC_DONE : ACC_WAIT_IN;
                end else begin
                    state_d = ACC_IDLE;
                end
            end
            ACC_WAIT_IN: begin
                if (in_stb) begin
                    go_s    = 1'b1;
                    state_d = ACC_CALC;
                end else begin
                    state_d = ACC_WAIT_IN;
                end
            end
            ACC_CALC: begin
                if (add_done_s) begin
                    acc_d   = add_sum_s;
                    count_d = count_q - LEN_W'(1);
                    state_d = (count_q == LEN_W'(1)) ? ACC_DONE : ACC_WAIT_IN;
                end else begin
                    state_d = ACC_CALC;
                end
            end
            ACC_DONE: begin
                state_d = ACC_IDLE;
            end
            default: begin
                state_d = ACC_IDLE;
            end
        endcase
        // A strobe outside WAIT_IN is dropped; it is not counted toward len.
        overrun_d = overrun_d | (in_stb & ~in_rdy_q);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC_IDLE;
            count_q   <= '0;
            acc_q     <= 32'd0;
            overrun_q <= 1'b0;
            acc_out_q <= 32'd0;
            acc_stb_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            overrun_q <= overrun_d;
            acc_stb_q <= (state_q == ACC_DONE);
            if (state_q == ACC_DONE) begin
                acc_out_q <= acc_q;
            end
            busy_q    <= (state_d != ACC_IDLE);
            in_rdy_q  <= (state_d == ACC_WAIT_IN);
        end
    end

    assign in_rdy  = in_rdy_q;
    assign acc_out = acc_out_q;
    assign acc_stb = acc_stb_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
